// File: rtl/tdes_data_buffer_pkg.sv
// Shared definitions for the 3DES data buffer: register map offsets and FSM states.
// Pure declarations, no latency.
// No backpressure; used by the buffer top and its FIFOs.
package tdes_data_buffer_pkg;

  // Slave-side register map (HADDR[3:0])
  localparam logic [3:0] ADDR_MODE   = 4'h0;
  localparam logic [3:0] ADDR_KEY1   = 4'h1;
  localparam logic [3:0] ADDR_KEY2   = 4'h2;
  localparam logic [3:0] ADDR_KEY3   = 4'h3;
  localparam logic [3:0] ADDR_CHUNK  = 4'h4;
  localparam logic [3:0] ADDR_RESULT = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  // All four configuration registers written at least once
  localparam logic [3:0] LOAD_MASK_FULL = 4'b1111;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } buf_state_t;

  // Status word layout: result count above input count, both zero-extended to 8 bits
  function automatic logic [63:0] statusWord(input logic [7:0] outCnt, input logic [7:0] inCnt);
    return {48'b0, outCnt, inCnt};
  endfunction

endpackage

// File: rtl/tdes_data_buffer_if.sv
// Bundles the slave-side register bus and the core-side handshakes of the data buffer.
// Wiring only, no latency.
// Flow control is carried by in_valid/in_ready and out_valid/out_ready.
interface tdes_data_buffer_if;
  // Slave controller side
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        err;
  // 3DES core side
  logic        enc_dec;
  logic [63:0] key1;
  logic [63:0] key2;
  logic [63:0] key3;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  // Environment view: slave controller plus core
  modport master (
    output wr_en, rd_en, addr, wdata, in_ready, out_valid, out_data, busy,
    input  rdata, err, enc_dec, key1, key2, key3, in_valid, in_data, out_ready
  );

  // Buffer view
  modport slave (
    input  wr_en, rd_en, addr, wdata, in_ready, out_valid, out_data, busy,
    output rdata, err, enc_dec, key1, key2, key3, in_valid, in_data, out_ready
  );
endinterface

// File: rtl/tdes_data_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is visible combinationally on rdData.
// One cycle from push to visibility at the head.
// Push is dropped when full unless a pop frees the slot in the same cycle; pop when empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    cnt;
  logic             doPush;
  logic             doPop;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign rdData = mem[rdPtr];

  // A full FIFO can still take a push when the head leaves in the same cycle
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Pointers and occupancy; power-of-two depth makes the pointers wrap naturally
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      unique case ({doPush, doPop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once the count covers them
  always_ff @(posedge HCLK) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/tdes_data_buffer.sv
// Register/buffer stage between the slave controller and the 3DES core: mode/key regs, chunk and result FIFOs.
// Writes take effect at the clock edge; rdata and err are registered, valid the cycle after the access.
// in_valid only in RUN with chunks queued; out_ready drops when the result FIFO is full.
module tdes_data_buffer
  import tdes_data_buffer_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  tdes_data_buffer_if.slave bus
);
  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  buf_state_t       state;
  buf_state_t       stateNext;
  logic [3:0]       loadMask;
  logic             encDec;
  logic [63:0]      key1Reg;
  logic [63:0]      key2Reg;
  logic [63:0]      key3Reg;
  logic [63:0]      rdataReg;
  logic [63:0]      rdataNext;
  logic             errReg;

  logic             inFull;
  logic             inEmpty;
  logic [IN_CW-1:0] inCnt;
  logic [63:0]      inHead;
  logic             outFull;
  logic             outEmpty;
  logic [OUT_CW-1:0] outCnt;
  logic [63:0]      outHead;

  logic             isRun;
  logic             cfgAddr;
  logic             cfgOk;
  logic             cfgWr;
  logic             chunkWr;
  logic             inPush;
  logic             inPop;
  logic             outPush;
  logic             outPop;
  logic             wrErr;
  logic             rdErr;

  assign isRun = (state == RUN);

  // Core-side handshakes
  assign bus.in_valid  = isRun && !inEmpty;
  assign bus.in_data   = inHead;
  assign inPop         = bus.in_valid && bus.in_ready;
  assign bus.out_ready = !outFull;
  assign outPush       = bus.out_valid && bus.out_ready;

  // Configuration may only change while the core has nothing queued or in flight
  assign cfgAddr = (bus.addr[3:2] == 2'b00);
  assign cfgOk   = !isRun || (inEmpty && !bus.busy);
  assign cfgWr   = bus.wr_en && cfgAddr && cfgOk;

  // Chunks are accepted only once configured; a same-cycle pop frees a full FIFO's slot
  assign chunkWr = bus.wr_en && (bus.addr == ADDR_CHUNK);
  assign inPush  = chunkWr && isRun && (!inFull || inPop);

  // Any write that neither configures nor queues a chunk is rejected
  assign wrErr = bus.wr_en && !cfgWr && !inPush;

  // Read decode; a read colliding with a write is always rejected
  always_comb begin
    rdataNext = '0;
    rdErr     = 1'b0;
    outPop    = 1'b0;
    if (bus.rd_en) begin
      if (bus.wr_en) begin
        rdErr = 1'b1;
      end else begin
        unique case (bus.addr)
          ADDR_MODE:   rdataNext = {63'b0, encDec};
          ADDR_KEY1,
          ADDR_KEY2,
          ADDR_KEY3:   rdataNext = '0;
          ADDR_RESULT: begin
            if (outEmpty) begin
              rdErr = 1'b1;
            end else begin
              rdataNext = outHead;
              outPop    = 1'b1;
            end
          end
          ADDR_STATUS: rdataNext = statusWord(8'(outCnt), 8'(inCnt));
          default:     rdErr = 1'b1;
        endcase
      end
    end
  end

  // Read data and error pulse; rdata holds its last value between reads
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      rdataReg <= '0;
      errReg   <= 1'b0;
    end else begin
      if (bus.rd_en) rdataReg <= rdataNext;
      errReg <= wrErr || rdErr;
    end
  end

  // Mode and key registers, plus the record of which have been loaded since reset
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      encDec   <= 1'b0;
      key1Reg  <= '0;
      key2Reg  <= '0;
      key3Reg  <= '0;
      loadMask <= '0;
    end else if (cfgWr) begin
      unique case (bus.addr[1:0])
        2'd0:    encDec  <= bus.wdata[0];
        2'd1:    key1Reg <= bus.wdata;
        2'd2:    key2Reg <= bus.wdata;
        default: key3Reg <= bus.wdata;
      endcase
      if (!isRun) loadMask[bus.addr[1:0]] <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state <= UNCFG;
    else         state <= stateNext;
  end

  // Leave UNCFG one cycle after the last configuration register is loaded
  always_comb begin
    stateNext = state;
    unique case (state)
      UNCFG:   if (loadMask == LOAD_MASK_FULL) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = UNCFG;
    endcase
  end

  assign bus.rdata   = rdataReg;
  assign bus.err     = errReg;
  assign bus.enc_dec = encDec;
  assign bus.key1    = key1Reg;
  assign bus.key2    = key2Reg;
  assign bus.key3    = key3Reg;

  sync_fifo #(.WIDTH(64), .DEPTH(IN_DEPTH)) inFifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (inPush),
    .pop    (inPop),
    .wrData (bus.wdata),
    .rdData (inHead),
    .full   (inFull),
    .empty  (inEmpty),
    .count  (inCnt)
  );

  sync_fifo #(.WIDTH(64), .DEPTH(OUT_DEPTH)) outFifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (outPush),
    .pop    (outPop),
    .wrData (bus.out_data),
    .rdData (outHead),
    .full   (outFull),
    .empty  (outEmpty),
    .count  (outCnt)
  );

endmodule
